// File: rtl/fsk_mod_pkg.sv
// Shared types and constants for the FSK modulator.
`include "header.vh"

package fsk_mod_pkg;

    // Burst sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_MOD      = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    // Width of the channel index bus.
    localparam int CH_IDX_W = `CH_IDX_W;

endpackage

// File: rtl/fsk_dev_ramp.sv
// Slope limiter: moves the deviation one bounded step toward its target,
// landing exactly on the target when it is within one step.
module fsk_dev_ramp #(
    parameter int DEV_W    = 8,
    parameter int DEV_STEP = 16
) (
    input  logic signed [DEV_W-1:0] i_target,
    input  logic signed [DEV_W-1:0] i_dev,
    output logic signed [DEV_W-1:0] o_dev_next
);

    // Difference is one bit wider so it cannot overflow.
    localparam logic signed [DEV_W:0] STEP_W = (DEV_W+1)'(DEV_STEP);
    localparam logic [DEV_W-1:0]      STEP_N = DEV_W'(DEV_STEP);

    logic signed [DEV_W:0] w_diff;

    // Step toward the target by at most DEV_STEP, never overshooting.
    always_comb begin
        w_diff     = {i_target[DEV_W-1], i_target} - {i_dev[DEV_W-1], i_dev};
        o_dev_next = i_target;
        if (w_diff > STEP_W) begin
            o_dev_next = i_dev + STEP_N;
        end else if (w_diff < -STEP_W) begin
            o_dev_next = i_dev - STEP_N;
        end
    end

endmodule

// File: rtl/header.vh
// Shared build-time defaults for the FSK modulator.
`ifndef FSK_HEADER_VH
`define FSK_HEADER_VH

`define WARM_CYC  16
`define DEV_MAX   64
`define DEV_STEP  16
`define BASE_CODE 400
`define CH_STEP   2
`define CH_IDX_W  6

`endif

// File: rtl/fsk_mod.sv
// FSK modulator: burst sequencer (idle / PA warm-up / modulate / ramp-down)
// driving a DCO control word as channel base plus slope-limited deviation.
`include "header.vh"

module fsk_mod
    import fsk_mod_pkg::*;
#(
    parameter int WARM_CYC  = `WARM_CYC,
    parameter int DEV_W     = 8,
    parameter int DEV_MAX   = `DEV_MAX,
    parameter int DEV_STEP  = `DEV_STEP,
    parameter int DCO_W     = 12,
    parameter int BASE_CODE = `BASE_CODE,
    parameter int CH_STEP   = `CH_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [`CH_IDX_W-1:0] ch_idx,
    input  logic                 tx,
    input  logic                 tx_valid,
    output logic [DCO_W-1:0]     dco_word,
    output logic                 dco_valid,
    output logic                 pa_en,
    output logic                 busy
);

    localparam int CNT_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WARM_CYC - 1);
    localparam logic signed [DEV_W-1:0] DEV_POS  = DEV_W'(DEV_MAX);
    localparam logic signed [DEV_W-1:0] DEV_NEG  = DEV_W'(-DEV_MAX);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DCO_W-1:0]        r_base;
    logic signed [DEV_W-1:0] r_dev;
    logic signed [DEV_W-1:0] r_target;
    logic                    r_active;

    logic signed [DEV_W-1:0] w_target_next;
    logic signed [DEV_W-1:0] w_dev_next;
    logic [31:0]             w_base_full;

    // Channel base code; wraps modulo 2^DCO_W once truncated.
    assign w_base_full = 32'(BASE_CODE) + 32'(ch_idx) * 32'(CH_STEP);

    // Target for this edge; a bit strobe steers the ramp on the same edge.
    always_comb begin
        w_target_next = r_target;
        case (r_state)
            ST_MOD: begin
                if (!en) begin
                    w_target_next = '0;
                end else if (tx_valid) begin
                    w_target_next = tx ? DEV_POS : DEV_NEG;
                end
            end
            default: w_target_next = '0;
        endcase
    end

    fsk_dev_ramp #(
        .DEV_W    (DEV_W),
        .DEV_STEP (DEV_STEP)
    ) u_ramp (
        .i_target   (w_target_next),
        .i_dev      (r_dev),
        .o_dev_next (w_dev_next)
    );

    // Burst FSM with warm-up counter, latched channel base and deviation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_base   <= '0;
            r_dev    <= '0;
            r_target <= '0;
            r_active <= 1'b0;
        end else begin
            r_target <= w_target_next;
            r_dev    <= w_dev_next;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_base   <= w_base_full[DCO_W-1:0];
                        r_cnt    <= '0;
                        r_state  <= ST_WARMUP;
                        r_active <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (!en) begin
                        r_state <= ST_COOLDOWN;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_MOD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MOD: begin
                    if (!en) begin
                        r_state <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    // Re-enabling here does not cut the ramp short.
                    if (r_dev == '0) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers so reset clears them at once.
    assign dco_word  = r_base + {{(DCO_W-DEV_W){r_dev[DEV_W-1]}}, r_dev};
    assign dco_valid = r_active;
    assign pa_en     = r_active;
    assign busy      = r_active;

endmodule

// File: tb/tb_fsk_mod.sv
// Directed bench for fsk_mod: burst timing, modulation ramps, cooldown,
// asynchronous reset and base-code wrap.
module tb_fsk_mod;

    localparam int CW = fsk_mod_pkg::CH_IDX_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, tx, tx_valid;
    logic [CW-1:0] ch_idx;
    logic [11:0]   dco_word;
    logic          dco_valid, pa_en, busy;

    logic          en2, tx2, tx_valid2;
    logic [CW-1:0] ch_idx2;
    logic [11:0]   dco_word2;
    logic          dco_valid2, pa_en2, busy2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fsk_mod dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_idx    (ch_idx),
        .tx        (tx),
        .tx_valid  (tx_valid),
        .dco_word  (dco_word),
        .dco_valid (dco_valid),
        .pa_en     (pa_en),
        .busy      (busy)
    );

    fsk_mod #(.BASE_CODE(4090), .CH_STEP(2)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .en        (en2),
        .ch_idx    (ch_idx2),
        .tx        (tx2),
        .tx_valid  (tx_valid2),
        .dco_word  (dco_word2),
        .dco_valid (dco_valid2),
        .pa_en     (pa_en2),
        .busy      (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tx = 1'b0; tx_valid = 1'b0; ch_idx = 5;
        en2 = 1'b0; tx2 = 1'b0; tx_valid2 = 1'b0; ch_idx2 = 3;
        @(negedge clk);
        @(negedge clk);
        $display("step: reset held");
        chk("rst_dco", 32'(dco_word), 0);
        chk("rst_valid", 32'(dco_valid), 0);
        chk("rst_pa", 32'(pa_en), 0);
        chk("rst_busy", 32'(busy), 0);

        rst = 1'b0;
        tick();
        $display("step: idle after reset");
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pa", 32'(pa_en), 0);

        // Burst on channel 5 with strobes held high through warm-up.
        en = 1'b1; tx = 1'b1; tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) ch_idx = 9;
            $display("step: warmup cycle %0d dco=%0d", i, dco_word);
            chk("warm_dco", 32'(dco_word), 410);
            chk("warm_pa", 32'(pa_en), 1);
        end
        tick();
        $display("step: first MOD cycle dco=%0d", dco_word);
        chk("mod_entry_dco", 32'(dco_word), 410);
        chk("mod_entry_busy", 32'(busy), 1);

        // Strobe a one: ramp up by 16 per cycle, hold at +64.
        tick();
        tx_valid = 1'b0;
        $display("step: tx=1 strobe dco=%0d", dco_word);
        chk("up_0", 32'(dco_word), 426);
        for (int k = 1; k < 4; k++) begin
            tick();
            $display("step: ramp up %0d dco=%0d", k, dco_word);
            chk("up_k", 32'(dco_word), 32'(426 + 16 * k));
        end
        tick();
        chk("up_hold", 32'(dco_word), 474);

        // Strobe a zero: ramp down to -64.
        tx = 1'b0; tx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            tx_valid = 1'b0;
            $display("step: ramp down %0d dco=%0d", k, dco_word);
            chk("down_k", 32'(dco_word), 32'(458 - 16 * k));
        end

        // Drop enable for one cycle: cooldown completes regardless.
        en = 1'b0;
        tick();
        en = 1'b1;
        $display("step: cooldown start dco=%0d", dco_word);
        chk("cool_0", 32'(dco_word), 362);
        chk("cool_pa", 32'(pa_en), 1);
        tick(); chk("cool_1", 32'(dco_word), 378);
        tick(); chk("cool_2", 32'(dco_word), 394);
        tick(); chk("cool_3", 32'(dco_word), 410);
        chk("cool_busy", 32'(busy), 1);
        tick();
        $display("step: idle gap busy=%0d", busy);
        chk("gap_busy", 32'(busy), 0);
        chk("gap_pa", 32'(pa_en), 0);
        chk("gap_valid", 32'(dco_valid), 0);
        tick();
        $display("step: new warmup dco=%0d", dco_word);
        chk("rewarm_busy", 32'(busy), 1);
        chk("rewarm_dco", 32'(dco_word), 418);

        // Run to MOD and ramp to +64, then reset asynchronously.
        for (int k = 0; k < 16; k++) tick();
        tx = 1'b1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        $display("step: at +64 dco=%0d", dco_word);
        chk("peak_dco", 32'(dco_word), 482);
        #2 rst = 1'b1;
        #1;
        $display("step: async reset mid-burst dco=%0d", dco_word);
        chk("arst_dco", 32'(dco_word), 0);
        chk("arst_valid", 32'(dco_valid), 0);
        chk("arst_pa", 32'(pa_en), 0);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk);
        chk("arst_hold_dco", 32'(dco_word), 0);
        rst = 1'b0;
        tick();
        $display("step: fresh warmup after reset dco=%0d", dco_word);
        chk("post_rst_pa", 32'(pa_en), 1);
        chk("post_rst_dco", 32'(dco_word), 418);
        en = 1'b0;
        tick();
        tick();
        chk("abort_idle_busy", 32'(busy), 0);

        // Wrapping base code on the second instance.
        en2 = 1'b1;
        tick();
        $display("step: wrap warmup dco=%0d", dco_word2);
        chk("wrap_base", 32'(dco_word2), 0);
        chk("wrap_pa", 32'(pa_en2), 1);
        for (int k = 0; k < 16; k++) tick();
        tx2 = 1'b0; tx_valid2 = 1'b1;
        tick();
        tx_valid2 = 1'b0;
        $display("step: wrap dev=-16 dco=%0d", dco_word2);
        chk("wrap_neg", 32'(dco_word2), 4080);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fsk_mod.md
FSK_MOD -- requirements
Module: fsk_mod

Interface
REQ-001 Parameter WARM_CYC, 16, PA warm-up cycles at carrier before modulation starts.
REQ-002 Parameter DEV_W, 8, signed width of the frequency-deviation register.
REQ-003 Parameter DEV_MAX, 64, deviation magnitude for one data bit; must be less than 2^(DEV_W-1).
REQ-004 Parameter DEV_STEP, 16, maximum deviation change per clk cycle (ramp slope).
REQ-005 Parameter DCO_W, 12, width of the DCO control word.
REQ-006 Parameter BASE_CODE, 400, DCO code for channel index 0.
REQ-007 Parameter CH_STEP, 2, DCO code increment per channel index.
REQ-008 clk  input  1  single clock; all state is clocked on its rising edge.
REQ-009 rst  input  1  reset, asynchronous and active-high.
REQ-010 en  input  1  level-sensitive burst enable, driven by the same enable that drives the transmitter.
REQ-011 ch_idx  input  `CH_IDX_W  channel index.
REQ-012 tx  input  1  serial bit from the transmitter, sampled only when tx_valid=1.
REQ-013 tx_valid  input  1  one-cycle strobe per transmitted bit.
REQ-014 dco_word  output  DCO_W  DCO frequency control word.
REQ-015 dco_valid  output  1  dco_word is meaningful.
REQ-016 pa_en  output  1  power-amplifier enable.
REQ-017 busy  output  1  high when state is not IDLE.

Function
REQ-018 The FSM SHALL have four states, IDLE, WARMUP, MOD and COOLDOWN, held in a registered state variable.
REQ-019 In IDLE with en=1, the FSM SHALL latch base_r = BASE_CODE + ch_idx*CH_STEP (mod 2^DCO_W), clear the warm-up counter and go to WARMUP.
REQ-020 Changes to ch_idx outside IDLE SHALL be ignored until the next burst.
REQ-021 WARMUP: dev held at 0; the FSM SHALL go to MOD after exactly WARM_CYC cycles in WARMUP, or to COOLDOWN if en=0.
REQ-022 tx_valid SHALL be ignored in every state except MOD.
REQ-023 MOD: on each edge sampling tx_valid=1, target SHALL load +DEV_MAX if tx=1, else -DEV_MAX.
REQ-024 In MOD and on that same edge, dev SHALL step toward the new target.
REQ-025 Every cycle, dev SHALL move toward target by min(DEV_STEP, |target-dev|), never overshooting, and hold once equal.
REQ-026 MOD with en=0 SHALL go to COOLDOWN; target becomes 0.
REQ-027 COOLDOWN: dev ramps to 0 per REQ-025; when dev==0 the FSM SHALL go to IDLE on the next edge, regardless of en.
REQ-028 en=1 during COOLDOWN SHALL NOT abort the ramp-down; a new burst starts from IDLE.
REQ-029 dco_word SHALL equal base_r plus sign-extended dev, mod 2^DCO_W (wrap, no saturation), derived only from registers.
REQ-030 dco_valid and pa_en SHALL be 1 in WARMUP, MOD and COOLDOWN and 0 in IDLE.
REQ-031 Latency: a bit strobed at edge n SHALL first affect dco_word in the cycle after edge n.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE and dev=target=base_r=counter=0.
REQ-033 rst=1 SHALL immediately force dco_word=0, dco_valid=0, pa_en=0 and busy=0, including mid-burst.
REQ-034 After rst falls with en=1, the block SHALL start a fresh WARMUP.

Structure
REQ-035 WARM_CYC, DEV_MAX, DEV_STEP, BASE_CODE and CH_STEP defaults SHALL be defined as macros in the shared header.vh; `CH_IDX_W comes from the same header.
REQ-036 The slope limiter SHALL be a single sub-module fsk_dev_ramp (inputs target and dev; output next dev).
REQ-037 The FSM, counter and registers SHALL reside in fsk_mod.

Verification
REQ-038 Reset mid-MOD with dev=+64 -> all outputs 0 in the same cycle; state IDLE.
REQ-039 en=1, ch_idx=5 -> dco_word=410 for 16 cycles with pa_en=1, then MOD.
REQ-040 In MOD with ch_idx=5, strobe tx=1 -> dco_word 426, 442, 458, 474 over the next four cycles, then holds 474.
REQ-041 Then strobe tx=0 -> dco_word steps down by 16 per cycle to 346 after 8 cycles.
REQ-042 tx_valid pulses during WARMUP -> dco_word stays 410.
REQ-043 en=0 at dev=-64, with en re-asserted 1 cycle later -> dev ramps to 0 in 4 cycles, then IDLE for exactly one cycle, then a new WARMUP.
REQ-044 BASE_CODE=4090, CH_STEP=2, ch_idx=3 -> base_r wraps to 0, and dev=-16 gives dco_word=4080.
